rca_fa4bit: RTL and testbench



---
 rtl/rca_fa4bit.sv | 77 +++++++
 tb/tb_rca_fa4bit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/rca_fa4bit.sv
// Ripple-carry adder: a chain of full-adder cells plus a one-cycle registered result.
// Optional signed-overflow flag (ovf, ovf_q) is enabled by defining RCA_OVF_EN.

module rca_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

module rca_fa4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-2:0] c,
    output logic             cout,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic [WIDTH-1:0] s_q,
    output logic             cout_q
`ifdef RCA_OVF_EN
    ,
    output logic             ovf,
    output logic             ovf_q
`endif
);
    // k[i] is the carry into cell i; k[WIDTH] is the carry out of the MSB cell
    logic [WIDTH:0] k;

    assign k[0] = cin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            rca_fa_cell u_cell (
                .a  (A[i]),
                .b  (B[i]),
                .ci (k[i]),
                .s  (s[i]),
                .co (k[i+1])
            );
        end
    endgenerate

    assign c    = k[WIDTH-1:1];
    assign cout = k[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s;
            cout_q <= cout;
        end
    end

`ifdef RCA_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it
    assign ovf = k[WIDTH-1] ^ k[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf;
    end
`endif
endmodule

// File: tb/tb_rca_fa4bit.sv
// Self-checking bench for rca_fa4bit: directed test-plan vectors, reset checks,
// and randomized operands against an arithmetic reference model.

module tb_rca_fa4bit;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] s, s_q, A, B;
    logic [W-2:0] c;
    logic         cout, cout_q, cin;
`ifdef RCA_OVF_EN
    logic         ovf, ovf_q;
`endif

    int tests = 0;
    int fails = 0;

    // expected registered values, captured from the model at each edge
    logic [W-1:0] exp_sq;
    logic         exp_coq;
    logic         exp_ovq;

    rca_fa4bit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .s      (s),
        .c      (c),
        .cout   (cout),
        .A      (A),
        .B      (B),
        .cin    (cin),
        .s_q    (s_q),
        .cout_q (cout_q)
`ifdef RCA_OVF_EN
        ,
        .ovf    (ovf),
        .ovf_q  (ovf_q)
`endif
    );

    always #5 clk = ~clk;

    function automatic int m_total(input int a, input int b, input int ci);
        return a + b + ci;
    endfunction

    // carry out of bit i = overflow of the low (i+1) bits added together
    function automatic logic [W-2:0] m_carries(input int a, input int b, input int ci);
        logic [W-2:0] r;
        for (int i = 0; i < W - 1; i++) begin
            int m;
            m = 1 << (i + 1);
            r[i] = (((a % m) + (b % m) + ci) >= m);
        end
        return r;
    endfunction

    function automatic logic m_ovf(input int a, input int b, input int ci);
        int sa, sb, t;
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        t  = sa + sb + ci;
        return (t > (1 << (W - 1)) - 1) || (t < -(1 << (W - 1)));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drive operands, check combinational outputs, and record expected register load
    task automatic apply(input int a, input int b, input int ci, input string tag);
        int t;
        @(negedge clk);
        A = W'(a); B = W'(b); cin = ci[0];
        #1;
        t = m_total(a, b, ci);
        chk({tag, ".s"},    32'(s),    32'(t % (1 << W)));
        chk({tag, ".c"},    32'(c),    32'(m_carries(a, b, ci)));
        chk({tag, ".cout"}, 32'(cout), 32'(t >> W));
`ifdef RCA_OVF_EN
        chk({tag, ".ovf"},  32'(ovf),  32'(m_ovf(a, b, ci)));
`endif
        exp_sq  = W'(t % (1 << W));
        exp_coq = (t >> W) != 0;
        exp_ovq = m_ovf(a, b, ci);
    endtask

    task automatic tick_check(input string tag);
        @(posedge clk);
        #1;
        if (rst) begin
            exp_sq = '0; exp_coq = 1'b0; exp_ovq = 1'b0;
        end
        chk({tag, ".s_q"},    32'(s_q),    32'(exp_sq));
        chk({tag, ".cout_q"}, 32'(cout_q), 32'(exp_coq));
`ifdef RCA_OVF_EN
        chk({tag, ".ovf_q"},  32'(ovf_q),  32'(exp_ovq));
`endif
    endtask

    initial begin
        rst = 1'b1; A = '0; B = '0; cin = 1'b0;
        exp_sq = '0; exp_coq = 1'b0; exp_ovq = 1'b0;

        // reset state
        apply(4'b1011, 4'b1110, 1, "rst_init");
        tick_check("rst_init");
        @(negedge clk); rst = 1'b0;

        // test-plan vectors
        apply(4'b1011, 4'b1110, 1, "tp1");
        tick_check("tp1");
        chk("tp1.s_q_lit", 32'(s_q), 32'(4'b1010));
        apply(4'b1010, 4'b1010, 1, "tp2");
        chk("tp2.c_lit", 32'(c), 32'(3'b010));
        tick_check("tp2");
        apply(4'b0011, 4'b0110, 1, "tp3");
        tick_check("tp3");
        apply(4'b1001, 4'b1111, 1, "tp4");
        tick_check("tp4");
        apply(4'b1111, 4'b0000, 1, "ripple");
        chk("ripple.c_lit", 32'(c), 32'(3'b111));
        tick_check("ripple");
        apply(4'b0000, 4'b0000, 0, "zero");
        tick_check("zero");
        apply(4'b1111, 4'b1111, 1, "max");
        tick_check("max");
        apply(4'b0111, 4'b0001, 0, "sovf");
        tick_check("sovf");

        // reset mid-stream: registers clear, combinational path keeps tracking
        apply(4'b1100, 4'b0111, 1, "pre_rst");
        tick_check("pre_rst");
        @(negedge clk); rst = 1'b1;
        tick_check("mid_rst");
        apply(4'b0101, 4'b0110, 0, "during_rst");
        tick_check("during_rst");
        @(negedge clk); rst = 1'b0;
        apply(4'b1110, 4'b1101, 1, "post_rst");
        tick_check("post_rst");

        // randomized operands
        for (int n = 0; n < 60; n++) begin
            apply(int'($urandom_range(0, (1 << W) - 1)),
                  int'($urandom_range(0, (1 << W) - 1)),
                  int'($urandom_range(0, 1)), "rand");
            tick_check("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
